// File: rtl/vga_scanout_if.sv
// Frame buffer read port plus VGA pin bundle for vga_scanout.
// master = scanout engine, slave = frame buffer / DAC side.
interface vga_scanout_if;
    logic [16:0] vga_pixel_addr;
    logic [3:0]  vga_pixel_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic        frame_start;

    modport master (
        output vga_pixel_addr,
        input  vga_pixel_data,
        output vga_r, vga_g, vga_b,
        output vga_hsync, vga_vsync, vga_de, frame_start
    );

    modport slave (
        input  vga_pixel_addr,
        output vga_pixel_data,
        input  vga_r, vga_g, vga_b,
        input  vga_hsync, vga_vsync, vga_de, frame_start
    );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: 2x-upscaled 320x240 4-bit frame buffer to 4:4:4 RGB pins.
// Define VGA_PALETTE_EN to map pixels through a fixed CGA RGBI palette instead of greyscale.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int FB_WIDTH = 320
) (
    input  logic          gpu_clk,
    input  logic          gpu_rst,
    vga_scanout_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    logic [DW-1:0] div;
    logic          pix_en;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [16:0]   line_base;
    logic [16:0]   addr_next;
    logic [16:0]   pixel_addr;
    sync_t         sync_raw;
    sync_t         sync_d1;
    sync_t         sync_d2;
    logic [11:0]   colour;
    logic [11:0]   rgb;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pix_en      = (div == DIV_LAST);
        sync_raw    = SYNC_IDLE;
        sync_raw.de = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
        sync_raw.hs = !((h >= HS_START) && (h < HS_END));
        sync_raw.vs = !((v >= VS_START) && (v < VS_END));
        sync_raw.fs = pix_en && (h == '0) && (v == '0);
        // 2x horizontal upscale: each frame buffer column covers two screen pixels.
        addr_next   = sync_raw.de ? line_base + 17'(h >> 1) : line_base;
    end

    always_comb begin
        colour = 12'h000;
`ifdef VGA_PALETTE_EN
        case (vif.vga_pixel_data)
            4'd0:  colour = 12'h000;
            4'd1:  colour = 12'h00A;
            4'd2:  colour = 12'h0A0;
            4'd3:  colour = 12'h0AA;
            4'd4:  colour = 12'hA00;
            4'd5:  colour = 12'hA0A;
            4'd6:  colour = 12'hA50;
            4'd7:  colour = 12'hAAA;
            4'd8:  colour = 12'h555;
            4'd9:  colour = 12'h55F;
            4'd10: colour = 12'h5F5;
            4'd11: colour = 12'h5FF;
            4'd12: colour = 12'hF55;
            4'd13: colour = 12'hF5F;
            4'd14: colour = 12'hFF5;
            4'd15: colour = 12'hFFF;
            default: colour = 12'h000;
        endcase
`else
        colour = {3{vif.vga_pixel_data}};
`endif
    end

    // NOTE: sequential state uses <= so every register samples values from before the edge.
    always_ff @(posedge gpu_clk) begin
        if (gpu_rst) begin
            div        <= '0;
            h          <= '0;
            v          <= '0;
            line_base  <= '0;
            pixel_addr <= '0;
            sync_d1    <= SYNC_IDLE;
            sync_d2    <= SYNC_IDLE;
            rgb        <= '0;
        end else begin
            div <= pix_en ? '0 : div + DW'(1);
            if (pix_en) begin
                if (h == H_LAST) begin
                    h <= '0;
                    if (v == V_LAST) begin
                        v         <= '0;
                        line_base <= '0;
                    end else begin
                        v <= v + VW'(1);
                        // Advance after odd rows only (2x vertical), never past the last row.
                        if (v[0] && (v < VW'(V_ACTIVE - 1)))
                            line_base <= line_base + 17'(FB_WIDTH);
                    end
                end else begin
                    h <= h + HW'(1);
                end
            end
            // Read data for pixel_addr arrives during the next cycle, in step with sync_d1.
            pixel_addr <= addr_next;
            sync_d1    <= sync_raw;
            sync_d2    <= sync_d1;
            rgb        <= sync_d1.de ? colour : 12'h000;
        end
    end

    assign vif.vga_pixel_addr = pixel_addr;
    assign vif.vga_r          = rgb[11:8];
    assign vif.vga_g          = rgb[7:4];
    assign vif.vga_b          = rgb[3:0];
    assign vif.vga_hsync      = sync_d2.hs;
    assign vif.vga_vsync      = sync_d2.vs;
    assign vif.vga_de         = sync_d2.de;
    assign vif.frame_start    = sync_d2.fs;
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a full-size instance (line timing, addressing, colour)
// and a shrunken instance (frame timing, last address, mid-frame reset).
module tb_vga_scanout;
    logic gpu_clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 gpu_clk = ~gpu_clk;

    vga_scanout_if vif_a ();
    vga_scanout_if vif_b ();

    // Frame buffer model: each word holds the low nibble of its own address.
    assign vif_a.vga_pixel_data = vif_a.vga_pixel_addr[3:0];
    assign vif_b.vga_pixel_data = vif_b.vga_pixel_addr[3:0];

    vga_scanout dut_a (
        .gpu_clk (gpu_clk),
        .gpu_rst (rst_a),
        .vif     (vif_a)
    );

    // 24 x 12 totals, 16 x 8 active, 8-wide frame buffer, one pixel per clock.
    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1),   .FB_WIDTH(8)
    ) dut_b (
        .gpu_clk (gpu_clk),
        .gpu_rst (rst_b),
        .vif     (vif_b)
    );

    function automatic logic [11:0] exp_colour(input logic [3:0] idx);
        logic [11:0] c;
`ifdef VGA_PALETTE_EN
        case (idx)
            4'd0:  c = 12'h000;  4'd1:  c = 12'h00A;  4'd2:  c = 12'h0A0;  4'd3:  c = 12'h0AA;
            4'd4:  c = 12'hA00;  4'd5:  c = 12'hA0A;  4'd6:  c = 12'hA50;  4'd7:  c = 12'hAAA;
            4'd8:  c = 12'h555;  4'd9:  c = 12'h55F;  4'd10: c = 12'h5F5;  4'd11: c = 12'h5FF;
            4'd12: c = 12'hF55;  4'd13: c = 12'hF5F;  4'd14: c = 12'hFF5;  default: c = 12'hFFF;
        endcase
`else
        c = {idx, idx, idx};
`endif
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge gpu_clk);
    endtask

    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
    int de_cnt_a    = 0;
    int hs_low_a    = 0;
    int vs_low_a    = 0;
    int fs_cnt_a    = 0;
    int nfall_a     = 0;
    int hs_fall_a[2] = '{-1, -1};
    logic prev_hs_a = 1'b1;
    int de_frame_b  = 0;
    int de_vblank_b = 0;
    int vs_low_b    = 0;
    int vs_start_b  = -1;
    int nfs_b       = 0;
    int fs_t_b[4]   = '{-1, -1, -1, -1};
    int max_addr_b  = 0;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        rgb_a = {vif_a.vga_r, vif_a.vga_g, vif_a.vga_b};
        check("rst_hsync", 32'(vif_a.vga_hsync), 32'd1);
        check("rst_vsync", 32'(vif_a.vga_vsync), 32'd1);
        check("rst_de", 32'(vif_a.vga_de), 32'd0);
        check("rst_rgb", 32'(rgb_a), 32'd0);
        check("rst_addr", 32'(vif_a.vga_pixel_addr), 32'd0);
        check("rst_frame_start", 32'(vif_a.frame_start), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Cycle k: dut_a pins show counter state of cycle k-2, its address that of k-1.
        for (int k = 1; k <= 3400; k++) begin
            tick();
            rgb_a = {vif_a.vga_r, vif_a.vga_g, vif_a.vga_b};
            rgb_b = {vif_b.vga_r, vif_b.vga_g, vif_b.vga_b};

            if (vif_a.frame_start) fs_cnt_a++;
            if (k < 1600 && vif_a.vga_de) de_cnt_a++;
            if (k < 1600 && !vif_a.vga_hsync) hs_low_a++;
            if (!vif_a.vga_vsync) vs_low_a++;
            if (prev_hs_a && !vif_a.vga_hsync && nfall_a < 2) begin
                hs_fall_a[nfall_a] = k;
                nfall_a++;
            end
            prev_hs_a = vif_a.vga_hsync;

            case (k)
                1:    check("a_fs_before", 32'(vif_a.frame_start), 32'd0);
                2:    check("a_de_first", 32'(vif_a.vga_de), 32'd1);
                3:    check("a_fs_after_release", 32'(vif_a.frame_start), 32'd1);
                4: begin
                    check("a_fs_width", 32'(vif_a.frame_start), 32'd0);
                    check("a_addr_h1", 32'(vif_a.vga_pixel_addr), 32'd0);
                end
                5:    check("a_addr_h2", 32'(vif_a.vga_pixel_addr), 32'd1);
                10:   check("a_rgb_h4_first", 32'(rgb_a), 32'(exp_colour(4'h2)));
                11:   check("a_rgb_h4_second", 32'(rgb_a), 32'(exp_colour(4'h2)));
                26:   check("a_rgb_idx6", 32'(rgb_a), 32'(exp_colour(4'h6)));
                1280: check("a_addr_line0_last", 32'(vif_a.vga_pixel_addr), 32'd319);
                1281: begin
                    check("a_addr_line0_blank", 32'(vif_a.vga_pixel_addr), 32'd0);
                    check("a_de_last_px", 32'(vif_a.vga_de), 32'd1);
                    check("a_rgb_last_px", 32'(rgb_a), 32'(exp_colour(4'hF)));
                end
                1282: begin
                    check("a_de_blank", 32'(vif_a.vga_de), 32'd0);
                    check("a_rgb_blank", 32'(rgb_a), 32'd0);
                end
                1601: check("a_addr_line1_first", 32'(vif_a.vga_pixel_addr), 32'd0);
                2880: check("a_addr_line1_last", 32'(vif_a.vga_pixel_addr), 32'd319);
                3200: check("a_addr_line1_tail", 32'(vif_a.vga_pixel_addr), 32'd0);
                3201: check("a_addr_line2_first", 32'(vif_a.vga_pixel_addr), 32'd320);
                3205: check("a_addr_line2_h2", 32'(vif_a.vga_pixel_addr), 32'd321);
                default: ;
            endcase

            // dut_b: pins show flat counter index k-2 (one pixel per clock).
            if (k <= 289 && vif_b.vga_de) de_frame_b++;
            if (k >= 194 && k <= 289 && vif_b.vga_de) de_vblank_b++;
            if (k <= 289 && !vif_b.vga_vsync) begin
                if (vs_start_b < 0) vs_start_b = k;
                vs_low_b++;
            end
            if (vif_b.frame_start) begin
                if (nfs_b < 4) fs_t_b[nfs_b] = k;
                nfs_b++;
            end
            if (int'(vif_b.vga_pixel_addr) > max_addr_b) max_addr_b = int'(vif_b.vga_pixel_addr);

            case (k)
                25:  check("b_addr_line1_first", 32'(vif_b.vga_pixel_addr), 32'd0);
                49:  check("b_addr_line2_first", 32'(vif_b.vga_pixel_addr), 32'd8);
                184: check("b_addr_last_active", 32'(vif_b.vga_pixel_addr), 32'd31);
                418: check("b_de_before_reset", 32'(vif_b.vga_de), 32'd1);
                419: begin
                    check("b_midrst_hsync", 32'(vif_b.vga_hsync), 32'd1);
                    check("b_midrst_vsync", 32'(vif_b.vga_vsync), 32'd1);
                    check("b_midrst_de", 32'(vif_b.vga_de), 32'd0);
                    check("b_midrst_rgb", 32'(rgb_b), 32'd0);
                    check("b_midrst_addr", 32'(vif_b.vga_pixel_addr), 32'd0);
                    check("b_midrst_fs", 32'(vif_b.frame_start), 32'd0);
                end
                421: check("b_fs_pre_restart", 32'(vif_b.frame_start), 32'd0);
                423: check("b_fs_width", 32'(vif_b.frame_start), 32'd0);
                default: ;
            endcase

            // Mid-frame reset of dut_b while its counters sit at h=10, v=5.
            if (k == 418) rst_b = 1'b1;
            if (k == 420) rst_b = 1'b0;
        end

        check("a_de_cycles_line", 32'(de_cnt_a), 32'd1280);
        check("a_hsync_low_cycles", 32'(hs_low_a), 32'd192);
        check("a_hsync_first_fall", 32'(hs_fall_a[0]), 32'd1314);
        check("a_hsync_period", 32'(hs_fall_a[1] - hs_fall_a[0]), 32'd1600);
        check("a_vsync_idle", 32'(vs_low_a), 32'd0);
        check("a_fs_count", 32'(fs_cnt_a), 32'd1);
        check("b_de_frame", 32'(de_frame_b), 32'd128);
        check("b_de_vblank", 32'(de_vblank_b), 32'd0);
        check("b_vsync_start", 32'(vs_start_b), 32'd218);
        check("b_vsync_low", 32'(vs_low_b), 32'd48);
        check("b_fs_first", 32'(fs_t_b[0]), 32'd2);
        check("b_fs_period", 32'(fs_t_b[1] - fs_t_b[0]), 32'd288);
        check("b_fs_after_reset", 32'(fs_t_b[2]), 32'd422);
        check("b_fs_period_after_reset", 32'(fs_t_b[3] - fs_t_b[2]), 32'd288);
        check("b_fs_count", 32'(nfs_b), 32'd13);
        check("b_addr_max", 32'(max_addr_b), 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
